data_mem_responder: RTL

- Responder for the processor's data-memory port. It serves `address`, `write_data`, `wmask` and `wen` from the core and returns `read_data` combinationally in the same cycle, which is what the M stage requires.
- Decodes each access to one of three targets: word RAM, an MMIO console TX FIFO (drained over a valid/ready byte stream), or a 64-bit machine timer with a compare interrupt.
- Sits beside the core at SoC top level, alongside the instruction memory.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory port of the core plus the console TX byte stream and timer interrupt.
interface data_mem_responder_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        timer_irq;

    modport master (
        output address, write_data, wmask, wen, tx_ready,
        input  read_data, tx_data, tx_valid, timer_irq
    );

    modport slave (
        input  address, write_data, wmask, wen, tx_ready,
        output read_data, tx_data, tx_valid, timer_irq
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, console TX FIFO and 64-bit machine timer behind one port.
// Reads are combinational; all state changes on the rising edge of clk.
module data_mem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [9:0] REG_TXDATA  = 10'd0;
    localparam logic [9:0] REG_STATUS  = 10'd1;
    localparam logic [9:0] REG_MTIME_L = 10'd2;
    localparam logic [9:0] REG_MTIME_H = 10'd3;
    localparam logic [9:0] REG_CMP_L   = 10'd4;
    localparam logic [9:0] REG_CMP_H   = 10'd5;

    logic [31:0]   ram [MEM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [63:0]   mtime, mtimecmp, mtime_inc;
    logic          unmapped_err, overflow_err, timer_irq_q;

    logic          is_ram, is_mmio, is_write, mmio_write;
    logic [9:0]    reg_idx;
    logic [AW-1:0] word_idx;
    logic          fifo_full, fifo_empty, push_req, push, pop, w1c, set_unmapped;
    logic [31:0]   status, rdata;
    logic          unused_addr_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        for (int i = 0; i < 4; i++)
            result[8*i +: 8] = mask[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        return result;
    endfunction

    assign is_ram       = (bus.address[31:AW+2] == '0);
    assign is_mmio      = !is_ram && (bus.address[31:12] == MMIO_BASE[31:12]);
    assign word_idx     = bus.address[AW+1:2];
    assign reg_idx      = bus.address[11:2];
    assign unused_addr_bits = ^bus.address[1:0];

    assign is_write     = bus.wen && (bus.wmask != 4'b0000);
    assign mmio_write   = is_write && is_mmio;
    assign set_unmapped = !is_ram && !is_mmio;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == CW'(FIFO_DEPTH));
    assign push_req     = mmio_write && (reg_idx == REG_TXDATA) && bus.wmask[0];
    // Full is judged before the edge, so a same-cycle pop never rescues a push into a full FIFO.
    assign push         = push_req && !fifo_full && !reset;
    assign pop          = !fifo_empty && bus.tx_ready;
    assign w1c          = mmio_write && (reg_idx == REG_STATUS) && bus.wmask[0];
    assign mtime_inc    = mtime + 64'd1;

    always_ff @(posedge clk) begin
        if (is_write && is_ram && !reset) begin
            for (int i = 0; i < 4; i++)
                if (bus.wmask[i])
                    ram[word_idx][8*i +: 8] <= bus.write_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= bus.write_data[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Error flags: a set in the same cycle as its W1C wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            unmapped_err <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            unmapped_err <= set_unmapped | (unmapped_err & ~(w1c & bus.write_data[2]));
            overflow_err <= (push_req & fifo_full) | (overflow_err & ~(w1c & bus.write_data[3]));
        end
    end

    // A written half takes the write data; the other half still gets the pre-edge increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mtime       <= '0;
            mtimecmp    <= '1;
            timer_irq_q <= 1'b0;
        end else begin
            mtime[31:0]  <= (mmio_write && reg_idx == REG_MTIME_L)
                            ? merge_bytes(mtime[31:0], bus.write_data, bus.wmask) : mtime_inc[31:0];
            mtime[63:32] <= (mmio_write && reg_idx == REG_MTIME_H)
                            ? merge_bytes(mtime[63:32], bus.write_data, bus.wmask) : mtime_inc[63:32];
            if (mmio_write && reg_idx == REG_CMP_L)
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], bus.write_data, bus.wmask);
            if (mmio_write && reg_idx == REG_CMP_H)
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.write_data, bus.wmask);
            timer_irq_q <= (mtime >= mtimecmp);
        end
    end

    always_comb begin
        status          = '0;
        status[0]       = fifo_empty;
        status[1]       = fifo_full;
        status[2]       = unmapped_err;
        status[3]       = overflow_err;
        status[8 +: CW] = count;
    end

    always_comb begin
        rdata = '0;
        if (is_ram) begin
            rdata = ram[word_idx];
        end else if (is_mmio) begin
            case (reg_idx)
                REG_STATUS:  rdata = status;
                REG_MTIME_L: rdata = mtime[31:0];
                REG_MTIME_H: rdata = mtime[63:32];
                REG_CMP_L:   rdata = mtimecmp[31:0];
                REG_CMP_H:   rdata = mtimecmp[63:32];
                default:     rdata = '0;
            endcase
        end
    end

    assign bus.read_data = rdata;
    assign bus.tx_data   = fifo[rd_ptr];
    assign bus.tx_valid  = !fifo_empty;
    assign bus.timer_irq = timer_irq_q;
endmodule
